inst_block_reader: RTL and testbench

//  Memory-side responder for the fetcher's icache refill request. Accepts a block

---
 rtl/inst_block_reader_pkg.sv | 18 +
 rtl/inst_block_reader.sv | 162 ++++++++++++++++
 tb/tb_inst_block_reader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_block_reader_pkg.sv
// Shared types and constants for the instruction block reader.
// The reader fetches one aligned block of bytes from the byte-wide RAM
// and packs them little-endian into a single instruction block.
package inst_block_reader_pkg;

    // Reader states: idle, waiting for the load/store path to release the
    // RAM, streaming bytes out of the RAM, and the one-cycle finish pulse.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_BUS = 2'd1,
        ST_READ     = 2'd2,
        ST_DONE     = 2'd3
    } reader_state_t;

    localparam int DEFAULT_ADDR_WIDTH  = 32;
    localparam int DEFAULT_BLOCK_BYTES = 16;

endpackage : inst_block_reader_pkg

// File: rtl/inst_block_reader.sv
// Memory-side responder for the fetcher's icache refill request.
// On an enable pulse it latches the block-aligned base address, waits for
// the RAM port to be free, then issues BLOCK_BYTES consecutive byte reads.
// Each byte arrives one cycle after its address and is written into its
// slot of the instruction block. When the last byte lands, finish_sign
// pulses for one cycle. rollback_sign aborts any request without finishing.
module inst_block_reader
    import inst_block_reader_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int BLOCK_BYTES = DEFAULT_BLOCK_BYTES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     enable_sign,
    input  logic [ADDR_WIDTH-1:0]    pc_in,
    input  logic                     rollback_sign,
    output logic                     finish_sign,
    output logic [8*BLOCK_BYTES-1:0] inst_block,
    input  logic                     bus_busy,
    output logic                     bus_hold,
    output logic [ADDR_WIDTH-1:0]    mem_a,
    output logic                     mem_wr,
    input  logic [7:0]               mem_din
);

    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int CNT_W = OFF_W + 1;

    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(BLOCK_BYTES - 1);
    localparam logic [CNT_W-1:0]      ISSUE_END = CNT_W'(BLOCK_BYTES);
    localparam logic [CNT_W-1:0]      CAP_LAST  = CNT_W'(BLOCK_BYTES - 1);

    reader_state_t            r_state;
    logic                     r_finish;
    logic [8*BLOCK_BYTES-1:0] r_block;
    logic                     r_hold;
    logic [ADDR_WIDTH-1:0]    r_mem_a;
    logic [ADDR_WIDTH-1:0]    r_base;
    logic [CNT_W-1:0]         r_issue_cnt;   // addresses already issued
    logic [CNT_W-1:0]         r_cap_cnt;     // bytes already captured
    logic                     r_addr_valid;  // mem_a carries a live read this cycle
    logic                     r_data_valid;  // mem_din carries a live byte this cycle

    logic [ADDR_WIDTH-1:0]    w_aligned_pc;
    logic [ADDR_WIDTH-1:0]    w_start_addr;
    logic [ADDR_WIDTH-1:0]    w_next_addr;
    logic                     w_start_read;
    logic                     w_issue_done;
    logic                     w_last_cap;

    // Low offset bits of the requested pc are cleared so every block is aligned;
    // with an aligned base, base+k never carries out of the offset field.
    assign w_aligned_pc = pc_in & ~OFF_MASK;
    assign w_next_addr  = r_base + ADDR_WIDTH'(r_issue_cnt);
    assign w_issue_done = (r_issue_cnt == ISSUE_END);
    assign w_last_cap   = (r_cap_cnt == CAP_LAST);

    // A read starts straight from IDLE on a request with a free bus, or from
    // WAIT_BUS as soon as the load/store path lets go. From IDLE the base is
    // not latched yet, so the first address comes directly from pc_in.
    assign w_start_read = !bus_busy &&
                          (((r_state == ST_IDLE) && enable_sign) || (r_state == ST_WAIT_BUS));
    assign w_start_addr = (r_state == ST_IDLE) ? w_aligned_pc : r_base;

    assign finish_sign = r_finish;
    assign inst_block  = r_block;
    assign bus_hold    = r_hold;
    assign mem_a       = r_mem_a;
    assign mem_wr      = 1'b0;

    // Request FSM with registered outputs: issue addresses, capture bytes, pulse finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_finish     <= 1'b0;
            // NOTE: the block register is deliberately reset so inst_block reads
            // as zero after reset instead of carrying stale or X contents.
            r_block      <= '0;
            r_hold       <= 1'b0;
            r_mem_a      <= '0;
            r_base       <= '0;
            r_issue_cnt  <= '0;
            r_cap_cnt    <= '0;
            r_addr_valid <= 1'b0;
            r_data_valid <= 1'b0;
        end else if (rdy) begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the pre-edge values of counters and addresses.
            if (rollback_sign) begin
                r_state      <= ST_IDLE;
                r_finish     <= 1'b0;
                r_hold       <= 1'b0;
                r_mem_a      <= '0;
                r_issue_cnt  <= '0;
                r_cap_cnt    <= '0;
                r_addr_valid <= 1'b0;
                r_data_valid <= 1'b0;
            end else begin
                if (w_start_read) begin
                    r_state      <= ST_READ;
                    r_hold       <= 1'b1;
                    r_mem_a      <= w_start_addr;
                    r_issue_cnt  <= CNT_W'(1);
                    r_cap_cnt    <= '0;
                    r_addr_valid <= 1'b1;
                    r_data_valid <= 1'b0;
                end

                case (r_state)
                    ST_IDLE: begin
                        r_finish <= 1'b0;
                        if (enable_sign) begin
                            r_base <= w_aligned_pc;
                            if (bus_busy) begin
                                r_state <= ST_WAIT_BUS;
                            end
                        end
                    end

                    ST_WAIT_BUS: begin
                        r_finish <= 1'b0;
                    end

                    ST_READ: begin
                        // Issue side: one new address per cycle until all are out.
                        if (!w_issue_done) begin
                            r_mem_a     <= w_next_addr;
                            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                        end
                        r_addr_valid <= !w_issue_done;
                        r_data_valid <= r_addr_valid;

                        // Capture side: byte j is on mem_din one cycle after address j.
                        if (r_data_valid) begin
                            r_block[{r_cap_cnt[OFF_W-1:0], 3'b000} +: 8] <= mem_din;
                            r_cap_cnt <= r_cap_cnt + CNT_W'(1);
                            if (w_last_cap) begin
                                r_state      <= ST_DONE;
                                r_hold       <= 1'b0;
                                r_finish     <= 1'b1;
                                r_addr_valid <= 1'b0;
                                r_data_valid <= 1'b0;
                            end
                        end
                    end

                    ST_DONE: begin
                        r_finish <= 1'b0;
                        r_state  <= ST_IDLE;
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule : inst_block_reader

// File: tb/tb_inst_block_reader.sv
// Self-checking bench for inst_block_reader. A byte-addressed RAM model
// answers the reader; expected blocks, address sequences and finish cycles
// are derived from the request parameters (base, bus-busy cycles, freeze
// cycles) rather than from the reader's internal state.
module tb_inst_block_reader;

    logic         clk;
    logic         rst;
    logic         rdy;
    logic         enable_sign;
    logic [31:0]  pc_in;
    logic         rollback_sign;
    logic         finish_sign;
    logic [127:0] inst_block;
    logic         bus_busy;
    logic         bus_hold;
    logic [31:0]  mem_a;
    logic         mem_wr;
    logic [7:0]   mem_din;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram [int unsigned];

    inst_block_reader #(
        .ADDR_WIDTH  (32),
        .BLOCK_BYTES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .enable_sign   (enable_sign),
        .pc_in         (pc_in),
        .rollback_sign (rollback_sign),
        .finish_sign   (finish_sign),
        .inst_block    (inst_block),
        .bus_busy      (bus_busy),
        .bus_hold      (bus_hold),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .mem_din       (mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: data for the address presented in an active cycle appears on
    // mem_din in the next cycle; while rdy is low the output is held.
    always @(posedge clk) begin
        if (rdy) mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_block(input logic [31:0] base);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            m[8*i +: 8] = ram.exists(base + 32'(i)) ? ram[base + 32'(i)] : 8'h00;
        end
        return m;
    endfunction

    task automatic fill_random(input logic [31:0] base);
        for (int i = 0; i < 16; i++) ram[base + 32'(i)] = 8'($urandom);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One request from cycle 0 (enable sampled at the end of cycle 0).
    // busy_n: bus_busy high in cycles 0..busy_n-1.
    // frz_len cycles of rdy=0 starting at cycle frz_start (inside the read).
    // extra_en: extra enable pulses in cycle 5 and in the finish cycle.
    task automatic do_request(input string tag, input logic [31:0] pc, input int busy_n,
                              input int frz_start, input int frz_len, input bit extra_en);
        logic [31:0]  base;
        logic [31:0]  addrs[$];
        int           exp_fin;
        int           first_c;
        int           fin_c;
        int           n_fin;
        int           last_c;
        bit           hold_at_fin;
        bit           wr_seen;
        bit           seq_ok;
        logic [127:0] blk;

        base    = pc & ~32'hF;
        exp_fin = 18 + busy_n + frz_len;
        last_c  = extra_en ? exp_fin + 24 : exp_fin + 4;
        first_c = -1;
        fin_c   = -1;
        n_fin   = 0;
        hold_at_fin = 1'b1;
        wr_seen = 1'b0;
        blk     = '0;

        for (int c = 0; c <= last_c; c++) begin
            enable_sign = (c == 0) || (extra_en && (c == 5 || c == exp_fin));
            pc_in       = (c == 0) ? pc : pc + 32'h40;
            bus_busy    = (c < busy_n);
            rdy         = !(frz_len > 0 && c >= frz_start && c < frz_start + frz_len);
            @(negedge clk);
            if (bus_hold && (addrs.size() == 0 || mem_a != addrs[$])) begin
                if (addrs.size() == 0) first_c = c;
                addrs.push_back(mem_a);
            end
            if (finish_sign) begin
                n_fin++;
                if (fin_c < 0) begin
                    fin_c = c;
                    blk = inst_block;
                    hold_at_fin = bus_hold;
                end
            end
            if (mem_wr !== 1'b0) wr_seen = 1'b1;
            next_cycle();
        end
        enable_sign = 1'b0;
        bus_busy    = 1'b0;
        rdy         = 1'b1;

        seq_ok = (addrs.size() == 16);
        for (int i = 0; i < addrs.size() && i < 16; i++) begin
            if (addrs[i] !== base + 32'(i)) seq_ok = 1'b0;
        end

        check({tag, ".first_addr_cycle"}, 128'(first_c), 128'(1 + busy_n));
        check({tag, ".addr_sequence"}, 128'(seq_ok), 128'(1));
        check({tag, ".finish_cycle"}, 128'(fin_c), 128'(exp_fin));
        check({tag, ".finish_count"}, 128'(n_fin), 128'(1));
        check({tag, ".block"}, blk, model_block(base));
        check({tag, ".hold_at_finish"}, 128'(hold_at_fin), 128'(0));
        check({tag, ".mem_wr"}, 128'(wr_seen), 128'(0));
    endtask

    initial begin
        int n_fin;
        int n_hold;
        logic [31:0] pc;
        int busy_n;
        int frz_len;

        rst = 1'b1;
        rdy = 1'b1;
        enable_sign = 1'b0;
        pc_in = '0;
        rollback_sign = 1'b0;
        bus_busy = 1'b0;
        #1;

        // Reset state.
        check("reset.finish", 128'(finish_sign), 128'(0));
        check("reset.bus_hold", 128'(bus_hold), 128'(0));
        check("reset.mem_a", 128'(mem_a), 128'(0));
        check("reset.inst_block", inst_block, 128'(0));
        check("reset.mem_wr", 128'(mem_wr), 128'(0));
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        next_cycle();

        // Sequential bytes, unaligned pc inside the block.
        for (int i = 0; i < 16; i++) ram[32'h1000 + 32'(i)] = 8'(i);
        do_request("seq", 32'h0000_1008, 0, 0, 0, 1'b0);
        check("seq.const_block", inst_block, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

        // Asynchronous reset in the middle of a read.
        enable_sign = 1'b1;
        pc_in = 32'h1000;
        next_cycle();
        enable_sign = 1'b0;
        repeat (6) next_cycle();
        #2 rst = 1'b1;
        #1;
        check("midreset.finish", 128'(finish_sign), 128'(0));
        check("midreset.bus_hold", 128'(bus_hold), 128'(0));
        check("midreset.mem_a", 128'(mem_a), 128'(0));
        check("midreset.inst_block", inst_block, 128'(0));
        #1 rst = 1'b0;
        n_fin = 0;
        n_hold = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (finish_sign) n_fin++;
            if (bus_hold) n_hold++;
        end
        next_cycle();
        check("midreset.no_finish", 128'(n_fin), 128'(0));
        check("midreset.idle", 128'(n_hold), 128'(0));

        // Bus busy for 5 cycles.
        do_request("busy5", 32'h0000_1000, 5, 0, 0, 1'b0);

        // rdy low for 3 cycles while mem_a = base+8.
        do_request("freeze", 32'h0000_1004, 0, 9, 3, 1'b0);

        // Rollback during the read; an enable in the same cycle is dropped.
        enable_sign = 1'b1;
        pc_in = 32'h1000;
        next_cycle();
        enable_sign = 1'b0;
        repeat (9) next_cycle();
        rollback_sign = 1'b1;
        enable_sign = 1'b1;
        pc_in = 32'h3000;
        next_cycle();
        rollback_sign = 1'b0;
        enable_sign = 1'b0;
        @(negedge clk);
        check("rollback.finish", 128'(finish_sign), 128'(0));
        check("rollback.bus_hold", 128'(bus_hold), 128'(0));
        check("rollback.mem_a", 128'(mem_a), 128'(0));
        n_fin = 0;
        n_hold = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (finish_sign) n_fin++;
            if (bus_hold) n_hold++;
        end
        next_cycle();
        check("rollback.no_finish", 128'(n_fin), 128'(0));
        check("rollback.enable_dropped", 128'(n_hold), 128'(0));
        fill_random(32'h2000);
        do_request("after_rollback", 32'h0000_2000, 0, 0, 0, 1'b0);

        // Enable pulses during READ and DONE are ignored.
        fill_random(32'h2400);
        fill_random(32'h2440);
        do_request("extra_en", 32'h0000_2400, 0, 0, 0, 1'b1);

        // Randomized requests with random bus contention and freezes.
        for (int t = 0; t < 6; t++) begin
            pc      = {14'd0, 14'($urandom_range(0, 16383)), 4'($urandom)};
            busy_n  = int'($urandom_range(0, 4));
            frz_len = int'($urandom_range(0, 3));
            fill_random(pc & ~32'hF);
            do_request($sformatf("rand%0d", t), pc, busy_n,
                       busy_n + 2 + int'($urandom_range(0, 14)), frz_len, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_inst_block_reader
